// File: rtl/bxb_avalon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bxb_avalon_pkg                                                             |
// | Shared types and helpers for the bxb Avalon-MM burst-read responder.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bxb_avalon_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Byte-address to word-address shift for a given data width.
  function automatic int unsigned byte_shift(input int unsigned data_w);
    return clog2(data_w / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bxb_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bxb_sdp_ram                                                                |
// | Simple dual-port RAM, 1-cycle registered read, old data on collision.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bxb_sdp_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Write and read share one block so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/bxb_avalon_burst_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bxb_avalon_burst_read_responder                                            |
// | Avalon-MM burst-read slave serving bursts from a preloadable local RAM.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bxb_avalon_burst_read_responder
  import bxb_avalon_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BURST_W    = 10,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  bxb_clock,
  input  logic                  bxb_reset_n,
  input  logic [ADDR_W-1:0]     bxb_address,
  input  logic [BURST_W-1:0]    bxb_burstcount,
  input  logic                  bxb_read,
  output logic                  bxb_waitrequest,
  output logic [DATA_W-1:0]     bxb_readdata,
  output logic                  bxb_readdatavalid,
  input  logic                  bxb_stall,
  input  logic                  bxb_load_we,
  input  logic [DEPTH_LOG2-1:0] bxb_load_addr,
  input  logic [DATA_W-1:0]     bxb_load_data,
  output logic                  bxb_err_burst0,
  output logic                  bxb_busy
);

  localparam int unsigned c_BYTE_SHIFT = byte_shift(DATA_W);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [DEPTH_LOG2-1:0] w_ptr_nxt;
  logic [BURST_W-1:0]    r_beats;
  logic [BURST_W-1:0]    w_beats_nxt;
  logic                  r_waitrequest;
  logic                  r_issue_d;
  logic                  r_rdv;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [DATA_W-1:0]     w_ram_q;
  logic                  w_accept;
  logic                  w_issue;
  logic [ADDR_W-1:0]     w_word_addr;
  logic                  w_unused_addr;

  // Only the low DEPTH_LOG2 word bits index the RAM; the rest wrap away.
  assign w_word_addr   = bxb_address >> c_BYTE_SHIFT;
  assign w_unused_addr = ^w_word_addr;

  always_ff @(posedge bxb_clock or negedge bxb_reset_n) begin
    if (!bxb_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_beats_nxt = r_beats;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bxb_read && !r_waitrequest) begin
          w_accept    = 1'b1;
          w_ptr_nxt   = w_word_addr[DEPTH_LOG2-1:0];
          w_beats_nxt = (bxb_burstcount == '0) ? BURST_W'(1) : bxb_burstcount;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (!bxb_stall) begin
          w_issue     = 1'b1;
          w_ptr_nxt   = r_ptr + DEPTH_LOG2'(1);
          w_beats_nxt = r_beats - BURST_W'(1);
          if (r_beats == BURST_W'(1)) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Waitrequest tracks the next state so it drops right after the last issue.
  always_ff @(posedge bxb_clock or negedge bxb_reset_n) begin
    if (!bxb_reset_n) begin
      r_waitrequest <= 1'b1;
      r_ptr         <= '0;
      r_beats       <= '0;
      r_issue_d     <= 1'b0;
      r_rdv         <= 1'b0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
    end else begin
      r_waitrequest <= (w_state_nxt != IDLE);
      r_ptr         <= w_ptr_nxt;
      r_beats       <= w_beats_nxt;
      r_issue_d     <= w_issue;
      r_rdv         <= r_issue_d;
      if (r_issue_d) begin
        r_rdata <= w_ram_q;
      end
      if (w_accept && (bxb_burstcount == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  bxb_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (bxb_clock),
    .i_we    (bxb_load_we),
    .i_waddr (bxb_load_addr),
    .i_wdata (bxb_load_data),
    .i_re    (w_issue),
    .i_raddr (r_ptr),
    .o_rdata (w_ram_q)
  );

  assign bxb_waitrequest   = r_waitrequest;
  assign bxb_readdata      = r_rdata;
  assign bxb_readdatavalid = r_rdv;
  assign bxb_err_burst0    = r_err;
  assign bxb_busy          = (r_state == BURST) || r_issue_d;

endmodule
`default_nettype wire

// File: tb/tb_bxb_avalon_burst_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bxb_avalon_burst_read_responder                                         |
// | Directed bench for the burst-read responder with a 16-word RAM.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_bxb_avalon_burst_read_responder;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BURST_W    = 10;
  localparam int unsigned DEPTH_LOG2 = 4;

  logic                  bxb_clock = 1'b0;
  logic                  bxb_reset_n = 1'b0;
  logic [ADDR_W-1:0]     bxb_address = '0;
  logic [BURST_W-1:0]    bxb_burstcount = '0;
  logic                  bxb_read = 1'b0;
  logic                  bxb_waitrequest;
  logic [DATA_W-1:0]     bxb_readdata;
  logic                  bxb_readdatavalid;
  logic                  bxb_stall = 1'b0;
  logic                  bxb_load_we = 1'b0;
  logic [DEPTH_LOG2-1:0] bxb_load_addr = '0;
  logic [DATA_W-1:0]     bxb_load_data = '0;
  logic                  bxb_err_burst0;
  logic                  bxb_busy;

  bxb_avalon_burst_read_responder #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .BURST_W    (BURST_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .bxb_clock         (bxb_clock),
    .bxb_reset_n       (bxb_reset_n),
    .bxb_address       (bxb_address),
    .bxb_burstcount    (bxb_burstcount),
    .bxb_read          (bxb_read),
    .bxb_waitrequest   (bxb_waitrequest),
    .bxb_readdata      (bxb_readdata),
    .bxb_readdatavalid (bxb_readdatavalid),
    .bxb_stall         (bxb_stall),
    .bxb_load_we       (bxb_load_we),
    .bxb_load_addr     (bxb_load_addr),
    .bxb_load_data     (bxb_load_data),
    .bxb_err_burst0    (bxb_err_burst0),
    .bxb_busy          (bxb_busy)
  );

  always #5 bxb_clock = ~bxb_clock;

  int cyc = 0;
  always @(posedge bxb_clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] q_data[$];
  int                q_cyc[$];

  always @(negedge bxb_clock) begin
    if (bxb_readdatavalid === 1'b1) begin
      q_data.push_back(bxb_readdata);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge bxb_clock);
      #1;
    end
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (bxb_waitrequest !== 1'b0 && t < 20) begin
      step(1);
      t++;
    end
    chk({tag, "_ready"}, 64'(bxb_waitrequest), 64'd0);
  endtask

  // Returns the cycle stamp just after the accepting edge.
  task automatic start_burst(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [BURST_W-1:0] bc, output int acc);
    wait_ready(tag);
    bxb_address    = a;
    bxb_burstcount = bc;
    bxb_read       = 1'b1;
    step(1);
    acc      = cyc;
    bxb_read = 1'b0;
  endtask

  task automatic expect_beats(input string tag, input int acc, input int n,
                              input int exp_d [8], input int exp_off [8]);
    chk({tag, "_count"}, 64'(q_data.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i),
          (i < q_data.size()) ? q_data[i] : 64'hDEAD_BEEF, 64'(exp_d[i]));
      chk($sformatf("%s_off%0d", tag, i),
          (i < q_cyc.size()) ? 64'(q_cyc[i] - acc) : 64'hFFFF, 64'(exp_off[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    int t;

    step(2);
    chk("rst_waitrequest", 64'(bxb_waitrequest), 64'd1);
    chk("rst_rdv", 64'(bxb_readdatavalid), 64'd0);
    chk("rst_rdata", bxb_readdata, 64'd0);
    chk("rst_err", 64'(bxb_err_burst0), 64'd0);
    chk("rst_busy", 64'(bxb_busy), 64'd0);

    @(negedge bxb_clock);
    bxb_reset_n = 1'b1;
    step(1);
    chk("rel_waitrequest", 64'(bxb_waitrequest), 64'd0);

    for (int i = 0; i < 16; i++) begin
      bxb_load_we   = 1'b1;
      bxb_load_addr = DEPTH_LOG2'(i);
      bxb_load_data = 64'(i);
      step(1);
    end
    bxb_load_we = 1'b0;

    // Aligned burst of 4 from word 0.
    q_data.delete(); q_cyc.delete();
    start_burst("t1", 32'h0, 10'd4, acc);
    chk("t1_wr_hi", 64'(bxb_waitrequest), 64'd1);
    step(3);
    chk("t1_wr_hi3", 64'(bxb_waitrequest), 64'd1);
    step(1);
    chk("t1_wr_lo4", 64'(bxb_waitrequest), 64'd0);
    step(6);
    expect_beats("t1", acc, 4, '{0, 1, 2, 3, 0, 0, 0, 0}, '{2, 3, 4, 5, 0, 0, 0, 0});
    chk("t1_hold", bxb_readdata, 64'd3);
    chk("t1_busy", 64'(bxb_busy), 64'd0);

    // Unaligned start with one stalled issue cycle.
    q_data.delete(); q_cyc.delete();
    start_burst("t2", 32'h2C, 10'd3, acc);
    step(1);
    bxb_stall = 1'b1;
    step(1);
    bxb_stall = 1'b0;
    step(8);
    expect_beats("t2", acc, 3, '{5, 6, 7, 0, 0, 0, 0, 0}, '{2, 4, 5, 0, 0, 0, 0, 0});

    // Wrap past the top of a 16-word RAM.
    q_data.delete(); q_cyc.delete();
    start_burst("t3", 32'h70, 10'd4, acc);
    step(8);
    expect_beats("t3", acc, 4, '{14, 15, 0, 1, 0, 0, 0, 0}, '{2, 3, 4, 5, 0, 0, 0, 0});

    // Back-to-back bursts with read held high.
    q_data.delete(); q_cyc.delete();
    wait_ready("t4a");
    bxb_address    = 32'h0;
    bxb_burstcount = 10'd2;
    bxb_read       = 1'b1;
    step(1);
    acc = cyc;
    chk("t4_wr_hi", 64'(bxb_waitrequest), 64'd1);
    bxb_address    = 32'h40;
    bxb_burstcount = 10'd2;
    t = 0;
    while (bxb_waitrequest !== 1'b0 && t < 20) begin
      step(1);
      t++;
    end
    chk("t4b_ready", 64'(bxb_waitrequest), 64'd0);
    step(1);
    acc2     = cyc;
    bxb_read = 1'b0;
    chk("t4_acc_gap", 64'(acc2 - acc), 64'd3);
    chk("t4_wr_hi2", 64'(bxb_waitrequest), 64'd1);
    step(8);
    expect_beats("t4", acc, 4, '{0, 1, 8, 9, 0, 0, 0, 0}, '{2, 3, 5, 6, 0, 0, 0, 0});

    // Zero burstcount is served as one beat and flagged.
    chk("t5_err_pre", 64'(bxb_err_burst0), 64'd0);
    q_data.delete(); q_cyc.delete();
    start_burst("t5", 32'h18, 10'd0, acc);
    step(6);
    expect_beats("t5", acc, 1, '{3, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0});
    chk("t5_err", 64'(bxb_err_burst0), 64'd1);
    q_data.delete(); q_cyc.delete();
    start_burst("t5b", 32'h8, 10'd1, acc);
    step(6);
    expect_beats("t5b", acc, 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0});
    chk("t5_err_sticky", 64'(bxb_err_burst0), 64'd1);

    // Reset in the middle of an 8-beat burst.
    q_data.delete(); q_cyc.delete();
    start_burst("t6", 32'h0, 10'd8, acc);
    step(3);
    @(negedge bxb_clock);
    #1;
    bxb_reset_n = 1'b0;
    #1;
    chk("t6_rst_rdv", 64'(bxb_readdatavalid), 64'd0);
    chk("t6_rst_wr", 64'(bxb_waitrequest), 64'd1);
    chk("t6_rst_busy", 64'(bxb_busy), 64'd0);
    chk("t6_rst_err", 64'(bxb_err_burst0), 64'd0);
    step(2);
    @(negedge bxb_clock);
    bxb_reset_n = 1'b1;
    step(1);
    chk("t6_rel_wr", 64'(bxb_waitrequest), 64'd0);
    step(6);
    expect_beats("t6", acc, 2, '{0, 1, 0, 0, 0, 0, 0, 0}, '{2, 3, 0, 0, 0, 0, 0, 0});
    q_data.delete(); q_cyc.delete();
    start_burst("t6b", 32'h50, 10'd2, acc);
    step(6);
    expect_beats("t6b", acc, 2, '{10, 11, 0, 0, 0, 0, 0, 0}, '{2, 3, 0, 0, 0, 0, 0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
